// File: rtl/fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// fetch_ctrl_if
// Handshake bundle between the fetch sequencing controller and its
// neighbours (backend, branch predictor, fetch unit, decode queue).
//
//   Requests into the controller:
//     exc_valid/exc_pc          exception / trap redirect
//     mispred_valid/mispred_pc  backend mispredict redirect
//     bp_valid/bp_pc            predictor taken-branch redirect
//     halt_req                  level, request fetch halt
//     resume                    pulse, leave HALT
//     dq_pop                    decode queue popped one bundle
//   Controls out of the controller:
//     fetch_en, stall, redirect_en, redirect_pc, dq_flush,
//     halted, credits, err_credit
//
// modport master : the controller (fetch_ctrl)
// modport slave  : the environment driving requests / consuming controls
// ---------------------------------------------------------------------------
interface fetch_ctrl_if #(
    parameter int PC_W   = 32,
    parameter int QDEPTH = 4,
    parameter int CRED_W = $clog2(QDEPTH + 1)
);
    logic              exc_valid;
    logic [PC_W-1:0]   exc_pc;
    logic              mispred_valid;
    logic [PC_W-1:0]   mispred_pc;
    logic              bp_valid;
    logic [PC_W-1:0]   bp_pc;
    logic              halt_req;
    logic              resume;
    logic              dq_pop;

    logic              fetch_en;
    logic              stall;
    logic              redirect_en;
    logic [PC_W-1:0]   redirect_pc;
    logic              dq_flush;
    logic              halted;
    logic [CRED_W-1:0] credits;
    logic              err_credit;

    modport master (
        input  exc_valid, exc_pc, mispred_valid, mispred_pc,
               bp_valid, bp_pc, halt_req, resume, dq_pop,
        output fetch_en, stall, redirect_en, redirect_pc,
               dq_flush, halted, credits, err_credit
    );

    modport slave (
        output exc_valid, exc_pc, mispred_valid, mispred_pc,
               bp_valid, bp_pc, halt_req, resume, dq_pop,
        input  fetch_en, stall, redirect_en, redirect_pc,
               dq_flush, halted, credits, err_credit
    );
endinterface

// File: rtl/fetch_ctrl.sv
// ---------------------------------------------------------------------------
// fetch_ctrl
// Sequencing controller for the two-wide fetch stage. Arbitrates redirect
// sources (exception > mispredict > predictor), gates fetch with a credit
// counter sized to the decode queue, runs the post-redirect drain window and
// the halt / resume sequence. All outputs are registered.
//
// Ports:
//   clk    clock, everything on posedge
//   reset  synchronous active-high reset
//   bus    fetch_ctrl_if.master (requests in, fetch/queue controls out)
// ---------------------------------------------------------------------------
module fetch_ctrl #(
    parameter int PC_W      = 32,
    parameter int QDEPTH    = 4,
    parameter int FETCH_LAT = 3,
    parameter int CRED_W    = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    fetch_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(FETCH_LAT + 1);
    localparam logic [CRED_W-1:0] QDEPTH_C = CRED_W'(QDEPTH);
    localparam logic [CNT_W-1:0]  LAT_C    = CNT_W'(FETCH_LAT);

    typedef enum logic [1:0] {
        ST_RUN        = 2'd0,
        ST_DRAIN      = 2'd1,
        ST_HALT_DRAIN = 2'd2,
        ST_HALT       = 2'd3
    } state_t;

    // Redirect targets are word aligned: low two bits dropped.
    function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
        return {pc[PC_W-1:2], 2'b00};
    endfunction

    // Free-slot update: one issue consumes, one pop returns; saturates at both ends.
    function automatic logic [CRED_W-1:0] credit_update(
        input logic [CRED_W-1:0] cur,
        input logic              issue,
        input logic              pop
    );
        logic [CRED_W-1:0] res;
        res = cur;
        if (issue && !pop) begin
            if (cur != {CRED_W{1'b0}}) begin
                res = cur - CRED_W'(1);
            end else begin
                res = cur;
            end
        end else if (!issue && pop) begin
            if (cur != QDEPTH_C) begin
                res = cur + CRED_W'(1);
            end else begin
                res = cur;
            end
        end else begin
            res = cur;
        end
        return res;
    endfunction

    state_t            state_r, state_s;
    logic [CNT_W-1:0]  cnt_r, cnt_s;
    logic [CRED_W-1:0] credits_r, credits_s;
    logic              fetch_en_r, fetch_en_s;
    logic              stall_r, stall_s;
    logic              redirect_en_r, redirect_en_s;
    logic [PC_W-1:0]   redirect_pc_r, redirect_pc_s;
    logic              dq_flush_r, dq_flush_s;
    logic              halted_r, halted_s;
    logic              err_credit_r, err_credit_s;
    logic              pend_valid_r, pend_valid_s;
    logic              pend_exc_r, pend_exc_s;
    logic [PC_W-1:0]   pend_pc_r, pend_pc_s;

    logic              run_win_s;
    logic [PC_W-1:0]   run_pc_s;
    logic              bk_win_s;
    logic [PC_W-1:0]   bk_pc_s;
    logic              pop_err_s;
    logic              eff_valid_s;
    logic              eff_exc_s;
    logic [PC_W-1:0]   eff_pc_s;

    // Redirect arbitration: full priority in RUN, backend-only otherwise.
    always_comb begin
        run_win_s = bus.exc_valid | bus.mispred_valid | bus.bp_valid;
        bk_win_s  = bus.exc_valid | bus.mispred_valid;
        if (bus.exc_valid) begin
            run_pc_s = bus.exc_pc;
        end else if (bus.mispred_valid) begin
            run_pc_s = bus.mispred_pc;
        end else begin
            run_pc_s = bus.bp_pc;
        end
        if (bus.exc_valid) begin
            bk_pc_s = bus.exc_pc;
        end else begin
            bk_pc_s = bus.mispred_pc;
        end
        pop_err_s = bus.dq_pop & (credits_r == QDEPTH_C);
    end

    // Pending redirect seen while halted: exception outranks mispredict,
    // a newer request of equal rank replaces the older one.
    always_comb begin
        eff_valid_s = pend_valid_r;
        eff_exc_s   = pend_exc_r;
        eff_pc_s    = pend_pc_r;
        if (bus.exc_valid) begin
            eff_valid_s = 1'b1;
            eff_exc_s   = 1'b1;
            eff_pc_s    = bus.exc_pc;
        end else if (bus.mispred_valid && !(pend_valid_r && pend_exc_r)) begin
            eff_valid_s = 1'b1;
            eff_exc_s   = 1'b0;
            eff_pc_s    = bus.mispred_pc;
        end else begin
            eff_valid_s = pend_valid_r;
        end
    end

    // Next-state logic. cnt holds the drain cycles remaining, including the current one.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        case (state_r)
            ST_RUN: begin
                if (run_win_s) begin
                    state_s = ST_DRAIN;
                    cnt_s   = LAT_C;
                end else if (bus.halt_req) begin
                    state_s = ST_HALT_DRAIN;
                    cnt_s   = LAT_C;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (bk_win_s) begin
                    cnt_s = LAT_C;
                end else if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_RUN;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_HALT_DRAIN: begin
                if (bk_win_s) begin
                    state_s = ST_DRAIN;
                    cnt_s   = LAT_C;
                end else if (cnt_r <= CNT_W'(1)) begin
                    state_s = ST_HALT;
                    cnt_s   = {CNT_W{1'b0}};
                end else begin
                    cnt_s = cnt_r - CNT_W'(1);
                end
            end
            ST_HALT: begin
                if (bus.resume) begin
                    if (eff_valid_s) begin
                        state_s = ST_DRAIN;
                        cnt_s   = LAT_C;
                    end else begin
                        state_s = ST_RUN;
                    end
                end else begin
                    state_s = ST_HALT;
                end
            end
            default: begin
                state_s = ST_RUN;
                cnt_s   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Output logic: next values of every registered output.
    always_comb begin
        fetch_en_s    = 1'b0;
        redirect_en_s = 1'b0;
        redirect_pc_s = redirect_pc_r;
        dq_flush_s    = 1'b0;
        credits_s     = credits_r;
        err_credit_s  = err_credit_r;
        pend_valid_s  = pend_valid_r;
        pend_exc_s    = pend_exc_r;
        pend_pc_s     = pend_pc_r;
        stall_s       = (state_s == ST_HALT);
        halted_s      = (state_s == ST_HALT);
        case (state_r)
            ST_RUN: begin
                credits_s    = credit_update(credits_r, fetch_en_r, bus.dq_pop);
                err_credit_s = err_credit_r | pop_err_s;
                if (run_win_s) begin
                    redirect_en_s = 1'b1;
                    redirect_pc_s = align_pc(run_pc_s);
                    dq_flush_s    = 1'b1;
                end else if (bus.halt_req) begin
                    fetch_en_s = 1'b0;
                end else begin
                    // Issue only if a slot remains after this cycle's update.
                    fetch_en_s = (credits_s != {CRED_W{1'b0}});
                end
            end
            ST_DRAIN: begin
                // Pops here belong to discarded bundles and are not counted.
                if (bk_win_s) begin
                    redirect_en_s = 1'b1;
                    redirect_pc_s = align_pc(bk_pc_s);
                    dq_flush_s    = 1'b1;
                end else if (cnt_r <= CNT_W'(1)) begin
                    credits_s  = QDEPTH_C;
                    fetch_en_s = ~bus.halt_req;
                end else begin
                    dq_flush_s = 1'b1;
                end
            end
            ST_HALT_DRAIN: begin
                credits_s    = credit_update(credits_r, fetch_en_r, bus.dq_pop);
                err_credit_s = err_credit_r | pop_err_s;
                if (bk_win_s) begin
                    redirect_en_s = 1'b1;
                    redirect_pc_s = align_pc(bk_pc_s);
                    dq_flush_s    = 1'b1;
                end else begin
                    dq_flush_s = 1'b0;
                end
            end
            ST_HALT: begin
                credits_s    = credit_update(credits_r, fetch_en_r, bus.dq_pop);
                err_credit_s = err_credit_r | pop_err_s;
                if (bus.resume && eff_valid_s) begin
                    redirect_en_s = 1'b1;
                    redirect_pc_s = align_pc(eff_pc_s);
                    dq_flush_s    = 1'b1;
                    pend_valid_s  = 1'b0;
                    pend_exc_s    = 1'b0;
                end else begin
                    pend_valid_s = eff_valid_s;
                    pend_exc_s   = eff_exc_s;
                    pend_pc_s    = eff_pc_s;
                end
            end
            default: begin
                credits_s = QDEPTH_C;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_RUN;
            cnt_r         <= {CNT_W{1'b0}};
            credits_r     <= QDEPTH_C;
            fetch_en_r    <= 1'b0;
            stall_r       <= 1'b0;
            redirect_en_r <= 1'b0;
            redirect_pc_r <= {PC_W{1'b0}};
            dq_flush_r    <= 1'b0;
            halted_r      <= 1'b0;
            err_credit_r  <= 1'b0;
            pend_valid_r  <= 1'b0;
            pend_exc_r    <= 1'b0;
            pend_pc_r     <= {PC_W{1'b0}};
        end else begin
            state_r       <= state_s;
            cnt_r         <= cnt_s;
            credits_r     <= credits_s;
            fetch_en_r    <= fetch_en_s;
            stall_r       <= stall_s;
            redirect_en_r <= redirect_en_s;
            redirect_pc_r <= redirect_pc_s;
            dq_flush_r    <= dq_flush_s;
            halted_r      <= halted_s;
            err_credit_r  <= err_credit_s;
            pend_valid_r  <= pend_valid_s;
            pend_exc_r    <= pend_exc_s;
            pend_pc_r     <= pend_pc_s;
        end
    end

    assign bus.fetch_en    = fetch_en_r;
    assign bus.stall       = stall_r;
    assign bus.redirect_en = redirect_en_r;
    assign bus.redirect_pc = redirect_pc_r;
    assign bus.dq_flush    = dq_flush_r;
    assign bus.halted      = halted_r;
    assign bus.credits     = credits_r;
    assign bus.err_credit  = err_credit_r;

endmodule

// File: tb/tb_fetch_ctrl.sv
module tb_fetch_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    fetch_ctrl_if #(.PC_W(32), .QDEPTH(4)) bus ();

    fetch_ctrl #(.PC_W(32), .QDEPTH(4), .FETCH_LAT(3)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        ev;
        logic [31:0] epc;
        logic        mv;
        logic [31:0] mpc;
        logic        bv;
        logic [31:0] bpc;
        logic        halt;
        logic        res;
        logic        pop;
        logic        fe;
        logic        st;
        logic        ren;
        logic [31:0] rpc;
        logic        fl;
        logic        hd;
        logic [2:0]  cr;
        logic        err;
    } vec_t;

    vec_t vq[$];

    function automatic vec_t mk(
        input logic ev, input logic [31:0] epc, input logic mv, input logic [31:0] mpc,
        input logic bv, input logic [31:0] bpc, input logic halt, input logic res,
        input logic pop, input logic fe, input logic st, input logic ren,
        input logic [31:0] rpc, input logic fl, input logic hd, input logic [2:0] cr,
        input logic err);
        vec_t v;
        v.ev = ev; v.epc = epc; v.mv = mv; v.mpc = mpc; v.bv = bv; v.bpc = bpc;
        v.halt = halt; v.res = res; v.pop = pop;
        v.fe = fe; v.st = st; v.ren = ren; v.rpc = rpc; v.fl = fl; v.hd = hd;
        v.cr = cr; v.err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic fe, input logic st,
                            input logic ren, input logic [31:0] rpc, input logic fl,
                            input logic hd, input logic [2:0] cr, input logic err);
        chk({tag, ".fetch_en"},    32'(bus.fetch_en),    32'(fe));
        chk({tag, ".stall"},       32'(bus.stall),       32'(st));
        chk({tag, ".redirect_en"}, 32'(bus.redirect_en), 32'(ren));
        if (ren) begin
            chk({tag, ".redirect_pc"}, bus.redirect_pc, rpc);
        end
        chk({tag, ".dq_flush"},    32'(bus.dq_flush),    32'(fl));
        chk({tag, ".halted"},      32'(bus.halted),      32'(hd));
        chk({tag, ".credits"},     32'(bus.credits),     32'(cr));
        chk({tag, ".err_credit"},  32'(bus.err_credit),  32'(err));
    endtask

    task automatic idle_in();
        bus.exc_valid = 1'b0; bus.exc_pc = 32'h0;
        bus.mispred_valid = 1'b0; bus.mispred_pc = 32'h0;
        bus.bp_valid = 1'b0; bus.bp_pc = 32'h0;
        bus.halt_req = 1'b0; bus.resume = 1'b0; bus.dq_pop = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic apply(input vec_t v);
        bus.exc_valid = v.ev; bus.exc_pc = v.epc;
        bus.mispred_valid = v.mv; bus.mispred_pc = v.mpc;
        bus.bp_valid = v.bv; bus.bp_pc = v.bpc;
        bus.halt_req = v.halt; bus.resume = v.res; bus.dq_pop = v.pop;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        idle_in();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        chk_outs("reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd4, 1'b0);

        //              ev   epc      mv   mpc      bv   bpc      hlt  res  pop   fe   st   ren  rpc      fl   hd   cr    err
        // credits run down with no pops, then one pop buys one bundle
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd3,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd1,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd0,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd0,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b1, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd1,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd0,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd0,1'b0));
        // three-way redirect: exception wins, 3-cycle drain, credits refilled
        vq.push_back(mk(1'b1,32'h100, 1'b1,32'h200, 1'b1,32'h300, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,32'h100,1'b1,1'b0,3'd0,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd0,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd0,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd3,1'b0));
        // predictor redirect, then bp ignored in drain, mispredict reloads drain
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b1,32'h51,  1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,32'h50, 1'b1,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b1,32'h400, 1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b1,32'h207, 1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b1,32'h204,1'b1,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd3,1'b0));
        // halt at credits=2, pops counted in halt drain, exc pending, resume redirects
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b1,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd2,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd3,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b1,1'b0,1'b1, 1'b0,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0,  1'b0,1'b1,3'd4,1'b0));
        vq.push_back(mk(1'b1,32'h80,  1'b0,32'h0,   1'b1,32'h600, 1'b1,1'b0,1'b0, 1'b0,1'b1,1'b0,32'h0,  1'b0,1'b1,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b1,1'b0, 1'b0,1'b0,1'b1,32'h80, 1'b1,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b0,1'b0,1'b0,32'h0,  1'b1,1'b0,3'd4,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b0,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd4,1'b0));
        // resume outside HALT is ignored; redirect beats halt_req
        vq.push_back(mk(1'b0,32'h0,   1'b0,32'h0,   1'b0,32'h0,   1'b0,1'b1,1'b0, 1'b1,1'b0,1'b0,32'h0,  1'b0,1'b0,3'd3,1'b0));
        vq.push_back(mk(1'b0,32'h0,   1'b1,32'h300, 1'b0,32'h0,   1'b1,1'b0,1'b0, 1'b0,1'b0,1'b1,32'h300,1'b1,1'b0,3'd2,1'b0));

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
            step();
            chk_outs($sformatf("vec%0d", i), vq[i].fe, vq[i].st, vq[i].ren, vq[i].rpc,
                     vq[i].fl, vq[i].hd, vq[i].cr, vq[i].err);
        end

        // Pop with a full credit pool: sticky error, credits held at 4.
        idle_in();
        reset = 1'b1;
        step();
        reset = 1'b0;
        bus.dq_pop = 1'b1;
        step();
        chk_outs("pop_full", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd4, 1'b1);
        bus.dq_pop = 1'b0;
        step();
        chk_outs("err_sticky", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd3, 1'b1);

        // Reset in the middle of a drain window.
        bus.exc_valid = 1'b1;
        bus.exc_pc    = 32'h10;
        step();
        chk_outs("mid_redir", 1'b0, 1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 3'd2, 1'b1);
        idle_in();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_outs("drain_reset", 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd4, 1'b0);
        chk("drain_reset.redirect_pc", bus.redirect_pc, 32'h0);
        step();
        chk_outs("post_reset_run", 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 3'd4, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
Sequencing controller for the two-wide fetch stage. It arbitrates three redirect sources (exception, branch mispredict, branch predictor) and drives fetch's fetch_en, stall, redirect_en and redirect_pc. It uses a credit counter so that fetch never issues more bundles than the decode queue can hold. It also runs the post-redirect drain window and the halt/resume sequence. It sits between the backend and predictor on one side and fetch and the decode queue on the other.

Parameters:
PC_W, 32, program counter width
QDEPTH, 4, decode queue capacity in bundles (one bundle = FETCH_W instructions)
FETCH_LAT, 3, cycles from fetch_en sampled high to if_valid at decode queue input
CRED_W, $clog2(QDEPTH+1), credit counter width

Ports:
clk  in  1  clock; single clock domain, all logic on posedge clk
reset  in  1  synchronous, active-high reset
exc_valid  in  1  exception/trap redirect request
exc_pc  in  PC_W  exception vector target
mispred_valid  in  1  backend branch mispredict redirect
mispred_pc  in  PC_W  corrected target
bp_valid  in  1  predictor taken-branch redirect
bp_pc  in  PC_W  predicted target
halt_req  in  1  level; request fetch halt
resume  in  1  pulse; leave HALT
dq_pop  in  1  decode queue popped one bundle this cycle
fetch_en  out  1  to fetch: issue one bundle this cycle
stall  out  1  to fetch: hold output stage
redirect_en  out  1  to fetch: load redirect_pc
redirect_pc  out  PC_W  target, bits [1:0] forced to 0
dq_flush  out  1  clear decode queue, discard arriving bundles
halted  out  1  state == HALT
credits  out  CRED_W  current free-slot count (debug/verify)
err_credit  out  1  sticky: dq_pop seen with credits == QDEPTH

Behaviour:
- All outputs are registered. Reset values: fetch_en=0, stall=0, redirect_en=0, redirect_pc=0, dq_flush=0, halted=0, credits=QDEPTH, err_credit=0, state=RUN. A reset asserted in any state returns to these values on the next edge.
- States:
  - RUN: normal fetching.
  - DRAIN: fetch blocked, in-flight bundles discarded. Drain counter loaded with FETCH_LAT.
  - HALT_DRAIN: same as DRAIN, but exits to HALT.
  - HALT: fetch blocked until resume.
- Redirect selection, RUN state: priority exc > mispred > bp. A winner in cycle N produces the following in cycle N+1:
  - redirect_en=1 for one cycle, redirect_pc = winner_pc & ~3.
  - dq_flush=1 for the whole drain window.
  - fetch_en=0.
  - State moves to DRAIN with cnt=FETCH_LAT.
- DRAIN: fetch_en=0 and dq_flush=1. cnt decrements each cycle; when cnt reaches 0, state returns to RUN and credits=QDEPTH.
  - dq_pop is ignored in DRAIN.
  - An exc or mispred arriving in DRAIN re-redirects: new redirect_en pulse, new pc, cnt reloaded.
  - bp_valid in DRAIN is ignored (wrong-path source).
- fetch_en in RUN is 1 when all hold: no redirect winner this cycle, credits > 0 (counting this cycle's update), and halt_req == 0.
- Credit update in RUN: next credits = credits - fetch_en + dq_pop.
  - Simultaneous issue and pop leave credits unchanged.
  - A pop at credits == QDEPTH leaves credits at QDEPTH and sets err_credit.
  - credits never underflows.
- Halt: halt_req in RUN (with no redirect) causes fetch_en=0 and moves to HALT_DRAIN (cnt=FETCH_LAT, dq_flush=0, pops still counted). At cnt=0 the state is HALT.
- HALT outputs: stall=1, halted=1, fetch_en=0.
  - exc/mispred arriving in HALT is latched as pending (highest priority; the latest one wins within equal priority). bp is ignored.
  - resume in HALT: stall=0. With a pending target, issue redirect and go to DRAIN. Otherwise go to RUN. resume outside HALT is ignored.
- stall is asserted only in HALT, so fetch never drops a live bundle.
- A redirect has priority over halt_req in the same cycle; the halt is taken from RUN after the drain completes.

Test Plan:
- Reset, then no pops: fetch_en high exactly 4 cycles, then 0, credits=0. Pop once: credits=1, one more fetch_en pulse.
- exc_valid(pc=0x100), mispred_valid(pc=0x200) and bp_valid(pc=0x300) in the same cycle: next cycle redirect_en=1 with redirect_pc=0x100, dq_flush high for 3 cycles, fetch_en=0 for those 3 cycles, then credits=4 and fetch_en resumes.
- mispred(pc=0x204) at DRAIN cnt=1 and bp(pc=0x400) at cnt=2: second redirect_en carries 0x204, cnt reloads to 3, bp produces no pulse; redirect of 0x207 outputs 0x204.
- halt_req with credits=2 and pops during HALT_DRAIN: halted=1 and stall=1 after 3 cycles; exc(0x80) while halted then resume produces redirect_en with 0x80 and DRAIN.
- Pop while credits=4: err_credit=1 (sticky), credits stays 4. Reset mid-DRAIN: next cycle state RUN, credits=4, all outputs at reset values.
